// File: rtl/spi_sram_responder_pkg.sv
// Shared opcodes and FSM encoding for the SPI serial-SRAM responder.
package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_RDMR   = 3'd5,
    ST_IGNORE = 3'd6
  } state_e;

endpackage

// File: rtl/spi_sram_responder_sync.sv
// Two-flop synchronizer for one SPI pin plus rise/fall detection on the
// synchronized level.
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // metastability chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~prev_r;
  assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/spi_sram_responder.sv
// Oversampled SPI mode-0 responder emulating a 23LC-style serial SRAM on a
// byte-wide synchronous memory port with sequential auto-increment.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int         ADDR_BYTES = 2,
  parameter logic [7:0] MODE_REG   = 8'h40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spi_clk,
  input  logic                    spi_cs_n,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  output logic                    spi_miso_oe,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  output logic [7:0]              mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [7:0]              mem_rdata
);

  localparam int              AW         = 8 * ADDR_BYTES;
  localparam logic [AW-1:0]   ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [3:0]      LAST_ABYTE = 4'(ADDR_BYTES - 1);

  logic sck_level_s, sck_rise_s, sck_fall_s;
  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic mosi_level_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  spi_sync_edge u_sync_sck (
    .clk(clk), .rst_n(rst_n), .din(spi_clk),
    .level(sck_level_s), .rise(sck_rise_s), .fall(sck_fall_s)
  );
  spi_sync_edge u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );
  spi_sync_edge u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi_mosi),
    .level(mosi_level_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  assign unused_s = ^{sck_level_s, cs_rise_s, mosi_rise_s, mosi_fall_s};

  state_e          state_r;
  logic [2:0]      bit_cnt_r;
  logic [3:0]      addr_byte_cnt_r;
  logic [7:0]      rx_sh_r;
  logic [7:0]      tx_sh_r;
  logic [7:0]      pre_buf_r;
  logic [AW-1:0]   addr_r;
  logic [7:0]      wdata_r;
  logic            we_r;
  logic            re_r;
  logic            miso_r;
  logic            oe_r;
  logic            is_read_r;
  logic            load_pend_r;
  logic            first_load_r;
  logic            have_pre_r;

  logic [7:0]      rx_byte_s;
  logic            byte_done_s;

  assign rx_byte_s   = {rx_sh_r[6:0], mosi_level_s};
  assign byte_done_s = sck_rise_s && (bit_cnt_r == 3'd7);

  // protocol FSM, shift registers and memory strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      bit_cnt_r       <= 3'd0;
      addr_byte_cnt_r <= 4'd0;
      rx_sh_r         <= 8'h00;
      tx_sh_r         <= 8'h00;
      pre_buf_r       <= 8'h00;
      addr_r          <= {AW{1'b0}};
      wdata_r         <= 8'h00;
      we_r            <= 1'b0;
      re_r            <= 1'b0;
      miso_r          <= 1'b0;
      oe_r            <= 1'b0;
      is_read_r       <= 1'b0;
      load_pend_r     <= 1'b0;
      first_load_r    <= 1'b0;
      have_pre_r      <= 1'b0;
    end else if (cs_level_s) begin
      // deselect drops any partial byte and any write not yet strobed
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      rx_sh_r      <= 8'h00;
      we_r         <= 1'b0;
      re_r         <= 1'b0;
      miso_r       <= 1'b0;
      oe_r         <= 1'b0;
      load_pend_r  <= 1'b0;
      first_load_r <= 1'b0;
      have_pre_r   <= 1'b0;
    end else begin
      we_r        <= 1'b0;
      re_r        <= 1'b0;
      load_pend_r <= re_r;
      if (we_r) begin
        addr_r <= addr_r + ADDR_ONE;
      end
      if (sck_rise_s && (state_r != ST_IDLE)) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        rx_sh_r   <= rx_byte_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_r         <= ST_CMD;
            bit_cnt_r       <= 3'd0;
            rx_sh_r         <= 8'h00;
            addr_byte_cnt_r <= 4'd0;
          end
        end
        ST_CMD: begin
          if (byte_done_s) begin
            case (rx_byte_s)
              CMD_READ: begin
                state_r   <= ST_ADDR;
                is_read_r <= 1'b1;
              end
              CMD_WRITE: begin
                state_r   <= ST_ADDR;
                is_read_r <= 1'b0;
              end
              CMD_RDMR: begin
                state_r <= ST_RDMR;
                oe_r    <= 1'b1;
                tx_sh_r <= MODE_REG;
                miso_r  <= MODE_REG[7];
              end
              default: state_r <= ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (sck_rise_s) begin
            addr_r <= {addr_r[AW-2:0], mosi_level_s};
            if (bit_cnt_r == 3'd7) begin
              if (addr_byte_cnt_r == LAST_ABYTE) begin
                if (is_read_r) begin
                  state_r      <= ST_RDATA;
                  oe_r         <= 1'b1;
                  miso_r       <= 1'b0;
                  re_r         <= 1'b1;
                  first_load_r <= 1'b1;
                  have_pre_r   <= 1'b0;
                end else begin
                  state_r <= ST_WDATA;
                end
              end else begin
                addr_byte_cnt_r <= addr_byte_cnt_r + 4'd1;
              end
            end
          end
        end
        ST_WDATA: begin
          if (byte_done_s) begin
            we_r    <= 1'b1;
            wdata_r <= rx_byte_s;
          end
        end
        ST_RDATA: begin
          // first byte goes straight to MISO; later bytes wait in the prefetch buffer
          if (load_pend_r) begin
            if (first_load_r) begin
              tx_sh_r      <= mem_rdata;
              miso_r       <= mem_rdata[7];
              first_load_r <= 1'b0;
            end else begin
              pre_buf_r  <= mem_rdata;
              have_pre_r <= 1'b1;
            end
          end
          if (sck_fall_s) begin
            if (bit_cnt_r == 3'd0) begin
              if (have_pre_r) begin
                tx_sh_r    <= pre_buf_r;
                miso_r     <= pre_buf_r[7];
                have_pre_r <= 1'b0;
              end
            end else begin
              miso_r  <= tx_sh_r[6];
              tx_sh_r <= {tx_sh_r[6:0], 1'b0};
              if (bit_cnt_r == 3'd7) begin
                addr_r <= addr_r + ADDR_ONE;
                re_r   <= 1'b1;
              end
            end
          end
        end
        ST_RDMR: begin
          if (sck_fall_s) begin
            if (bit_cnt_r == 3'd0) begin
              tx_sh_r <= MODE_REG;
              miso_r  <= MODE_REG[7];
            end else begin
              miso_r  <= tx_sh_r[6];
              tx_sh_r <= {tx_sh_r[6:0], 1'b0};
            end
          end
        end
        ST_IGNORE: begin
          oe_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          oe_r    <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso    = miso_r;
  assign spi_miso_oe = oe_r;
  assign mem_addr    = addr_r;
  assign mem_wdata   = wdata_r;
  assign mem_we      = we_r;
  assign mem_re      = re_r;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: table of SPI transactions against a
// byte memory model, plus abort, deselect and reset sequences.
module tb_spi_sram_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;

  always #5 clk = ~clk;

  spi_sram_responder #(.ADDR_BYTES(2), .MODE_REG(8'h40)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  // synchronous byte memory with one-cycle read latency
  logic [7:0] mem [0:65535];
  logic       mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      mem[16'h0010] <= 8'h5A;
      mem_init_done <= 1'b1;
    end
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // strobe and output-enable recorder
  logic [15:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];
  logic [15:0] re_addr_q[$];
  int          oe_cnt = 0;
  int          overlap_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      we_addr_q.push_back(mem_addr);
      we_data_q.push_back(mem_wdata);
    end
    if (mem_re) re_addr_q.push_back(mem_addr);
    if (mem_we && mem_re) overlap_cnt <= overlap_cnt + 1;
    if (spi_miso_oe) oe_cnt <= oe_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_miso;
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    int          n;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          exp_we;
    int          exp_re;
    logic [7:0]  exp_rx0;
    logic [7:0]  exp_rx1;
    logic        exp_oe;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vec_t        t;
    logic [7:0]  junk, rx0, rx1, rxb;
    logic [15:0] ea;
    int          we_base, re_base, oe_start, oe_pre;
    logic        has_addr;

    vecs[0] = '{8'h02, 16'h1234, 2, 8'hAA, 8'h55, 2, 0, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'h03, 16'h1234, 2, 8'h00, 8'h00, 0, 3, 8'hAA, 8'h55, 1'b1};
    vecs[2] = '{8'h02, 16'h1234, 2, 8'hC3, 8'h3C, 2, 0, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'h03, 16'h1234, 2, 8'h00, 8'h00, 0, 3, 8'hC3, 8'h3C, 1'b1};
    vecs[4] = '{8'h02, 16'hFFFF, 2, 8'h11, 8'h22, 2, 0, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'h03, 16'hFFFF, 2, 8'h00, 8'h00, 0, 3, 8'h11, 8'h22, 1'b1};
    vecs[6] = '{8'h05, 16'h0000, 1, 8'h00, 8'h00, 0, 0, 8'h40, 8'h00, 1'b1};
    vecs[7] = '{8'h05, 16'h0000, 2, 8'h00, 8'h00, 0, 0, 8'h40, 8'h40, 1'b1};
    vecs[8] = '{8'h9F, 16'h0000, 2, 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00, 1'b0};
    vecs[9] = '{8'h01, 16'h0000, 1, 8'hAB, 8'h00, 0, 0, 8'h00, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {4'h0, mem_addr, mem_wdata, mem_we, mem_re, spi_miso, spi_miso_oe}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      t = vecs[v];
      we_base = we_addr_q.size();
      re_base = re_addr_q.size();
      oe_start = oe_cnt;
      has_addr = (t.cmd == 8'h02) || (t.cmd == 8'h03);
      rx0 = 8'h00;
      rx1 = 8'h00;
      cs_begin();
      if (has_addr) begin
        spi_bits(t.cmd, 8, junk);
        spi_bits(t.addr[15:8], 8, junk);
        oe_pre = oe_cnt;
        spi_bits(t.addr[7:0], 8, junk);
      end else begin
        oe_pre = oe_cnt;
        spi_bits(t.cmd, 8, junk);
      end
      if (t.n > 0) spi_bits(t.d0, 8, rx0);
      if (t.n > 1) spi_bits(t.d1, 8, rx1);
      cs_end();

      check($sformatf("v%0d_oe_header", v), oe_pre - oe_start, 0);
      check($sformatf("v%0d_oe_data", v), 32'((oe_cnt - oe_pre) > 0), 32'(t.exp_oe));
      check($sformatf("v%0d_oe_after_cs", v), 32'(spi_miso_oe), 0);
      check($sformatf("v%0d_we_count", v), we_addr_q.size() - we_base, t.exp_we);
      for (int k = 0; k < t.exp_we && we_base + k < we_addr_q.size(); k++) begin
        ea = t.addr + 16'(k);
        check($sformatf("v%0d_we_addr%0d", v, k), 32'(we_addr_q[we_base + k]), 32'(ea));
        check($sformatf("v%0d_we_data%0d", v, k), 32'(we_data_q[we_base + k]), 32'((k == 0) ? t.d0 : t.d1));
      end
      check($sformatf("v%0d_re_count", v), re_addr_q.size() - re_base, t.exp_re);
      for (int k = 0; k < t.exp_re && re_base + k < re_addr_q.size(); k++) begin
        ea = t.addr + 16'(k);
        check($sformatf("v%0d_re_addr%0d", v, k), 32'(re_addr_q[re_base + k]), 32'(ea));
      end
      check($sformatf("v%0d_rx0", v), 32'(rx0), 32'(t.exp_rx0));
      check($sformatf("v%0d_rx1", v), 32'(rx1), 32'(t.exp_rx1));
    end

    // partial data byte followed by deselect must not write
    we_base = we_addr_q.size();
    cs_begin();
    spi_bits(8'h02, 8, junk);
    spi_bits(8'h00, 8, junk);
    spi_bits(8'h10, 8, junk);
    spi_bits(8'hF0, 5, junk);
    cs_end();
    check("abort_no_write", we_addr_q.size() - we_base, 0);
    re_base = re_addr_q.size();
    cs_begin();
    spi_bits(8'h03, 8, junk);
    spi_bits(8'h00, 8, junk);
    spi_bits(8'h10, 8, junk);
    spi_bits(8'h00, 8, rxb);
    cs_end();
    check("abort_read_back", 32'(rxb), 32'h5A);
    check("abort_read_re_count", re_addr_q.size() - re_base, 2);

    // deselect in the middle of RDMR output
    cs_begin();
    spi_bits(8'h05, 8, junk);
    spi_bits(8'h00, 4, rxb);
    check("rdmr_partial_bits", 32'(rxb), 32'h40);
    check("rdmr_oe_active", 32'(spi_miso_oe), 1);
    spi_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("cs_high_oe_3clk", {30'h0, spi_miso_oe, spi_miso}, 0);
    repeat (2 * HALF) @(negedge clk);

    // reset in the middle of a read data byte
    cs_begin();
    spi_bits(8'h03, 8, junk);
    spi_bits(8'h12, 8, junk);
    spi_bits(8'h34, 8, junk);
    spi_bits(8'h00, 4, rxb);
    check("reset_pre_read_nibble", 32'(rxb), 32'hC0);
    check("reset_pre_oe", 32'(spi_miso_oe), 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_read_outputs", {4'h0, mem_addr, mem_wdata, mem_we, mem_re, spi_miso, spi_miso_oe}, 32'h0);
    we_base = we_addr_q.size();
    re_base = re_addr_q.size();
    repeat (10) @(negedge clk);
    spi_clk = 1'b0;
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_no_strobes", (we_addr_q.size() - we_base) + (re_addr_q.size() - re_base), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    we_base = we_addr_q.size();
    cs_begin();
    spi_bits(8'h02, 8, junk);
    spi_bits(8'h00, 8, junk);
    spi_bits(8'h20, 8, junk);
    spi_bits(8'h77, 8, junk);
    cs_end();
    check("post_reset_we_count", we_addr_q.size() - we_base, 1);
    if (we_addr_q.size() > we_base) begin
      check("post_reset_we_addr", 32'(we_addr_q[we_base]), 32'h0020);
      check("post_reset_we_data", 32'(we_data_q[we_base]), 32'h77);
    end
    cs_begin();
    spi_bits(8'h03, 8, junk);
    spi_bits(8'h00, 8, junk);
    spi_bits(8'h20, 8, junk);
    spi_bits(8'h00, 8, rxb);
    cs_end();
    check("post_reset_read", 32'(rxb), 32'h77);

    check("strobe_overlap", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
